// File: rtl/matrix_mult_sequencer_if.sv
// Stream and multiplier-control bundle for matrix_mult_sequencer.
interface matrix_mult_sequencer_if;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] out_data;
  logic [3:0] out_idx;
  logic       out_last;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic [3:0] mm_i;
  logic       mm_ic;
  logic [3:0] mm_os;
  logic       mm_en;
  logic       mm_mr;
  logic [9:0] mm_matrix;

  modport master (
    input  in_data, in_valid, out_ready, mm_matrix,
    output in_ready, out_data, out_idx, out_last, out_valid, busy,
    output mm_i, mm_ic, mm_os, mm_en, mm_mr
  );

  modport slave (
    output in_data, in_valid, out_ready, mm_matrix,
    input  in_ready, out_data, out_idx, out_last, out_valid, busy,
    input  mm_i, mm_ic, mm_os, mm_en, mm_mr
  );
endinterface

// File: rtl/matrix_mult_sequencer.sv
// Sequences operand load, compute strobes and result drain for a serial 3x3 multiplier.
module matrix_mult_sequencer #(
  parameter int unsigned IC_HIGH = 1,
  parameter int unsigned IC_LOW  = 1,
  parameter int unsigned SETTLE  = 1
) (
  input logic                       clk,
  input logic                       mr,
  matrix_mult_sequencer_if.master   bus
);

  typedef enum logic [1:0] {StClr, StLoad, StCompute, StDrain} state_e;
  // In DRAIN, PhSetup is the settle wait and PhIdle is presenting a result.
  typedef enum logic [1:0] {PhIdle, PhSetup, PhHigh, PhLow} phase_e;

  state_e     state_q;
  phase_e     phase_q;
  logic [7:0] cnt_q;
  logic [4:0] elem_q;
  logic       in_ready_q, out_valid_q, out_last_q, busy_q;
  logic [9:0] out_data_q;
  logic [3:0] out_idx_q, mm_i_q, mm_os_q;
  logic       mm_ic_q, mm_en_q, mm_mr_q;

  always_ff @(posedge clk or negedge mr) begin
    if (!mr) begin
      state_q     <= StClr;
      phase_q     <= PhIdle;
      cnt_q       <= '0;
      elem_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b1;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      mm_i_q      <= '0;
      mm_os_q     <= '0;
      mm_ic_q     <= 1'b0;
      mm_en_q     <= 1'b0;
      mm_mr_q     <= 1'b1;
    end else begin
      unique case (state_q)
        StClr: begin
          if (cnt_q == 8'd1) begin
            cnt_q      <= '0;
            mm_mr_q    <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            elem_q     <= '0;
            phase_q    <= PhIdle;
            state_q    <= StLoad;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StLoad: begin
          case (phase_q)
            PhIdle: begin
              if (bus.in_valid && in_ready_q) begin
                mm_i_q     <= bus.in_data;
                in_ready_q <= 1'b0;
                busy_q     <= 1'b1;
                phase_q    <= PhSetup;
              end
            end
            PhSetup: begin
              mm_ic_q <= 1'b1;
              cnt_q   <= '0;
              phase_q <= PhHigh;
            end
            PhHigh: begin
              if (cnt_q == 8'(IC_HIGH - 1)) begin
                mm_ic_q <= 1'b0;
                cnt_q   <= '0;
                phase_q <= PhLow;
              end else begin
                cnt_q <= cnt_q + 8'd1;
              end
            end
            default: begin
              if (cnt_q == 8'(IC_LOW - 1)) begin
                cnt_q <= '0;
                if (elem_q == 5'd17) begin
                  elem_q  <= '0;
                  mm_i_q  <= '0;
                  phase_q <= PhSetup;
                  state_q <= StCompute;
                end else begin
                  elem_q     <= elem_q + 5'd1;
                  in_ready_q <= 1'b1;
                  phase_q    <= PhIdle;
                end
              end else begin
                cnt_q <= cnt_q + 8'd1;
              end
            end
          endcase
        end
        StCompute: begin
          case (phase_q)
            PhHigh: begin
              if (cnt_q == 8'(IC_HIGH - 1)) begin
                mm_ic_q <= 1'b0;
                cnt_q   <= '0;
                phase_q <= PhLow;
              end else begin
                cnt_q <= cnt_q + 8'd1;
              end
            end
            PhLow: begin
              if (cnt_q == 8'(IC_LOW - 1)) begin
                cnt_q <= '0;
                if (elem_q == 5'd8) begin
                  mm_os_q <= '0;
                  mm_en_q <= 1'b1;
                  phase_q <= PhSetup;
                  state_q <= StDrain;
                end else begin
                  elem_q  <= elem_q + 5'd1;
                  mm_ic_q <= 1'b1;
                  phase_q <= PhHigh;
                end
              end else begin
                cnt_q <= cnt_q + 8'd1;
              end
            end
            default: begin
              mm_ic_q <= 1'b1;
              cnt_q   <= '0;
              phase_q <= PhHigh;
            end
          endcase
        end
        StDrain: begin
          if (phase_q == PhSetup) begin
            if (cnt_q == 8'(SETTLE - 1)) begin
              out_data_q  <= bus.mm_matrix;
              out_idx_q   <= mm_os_q;
              out_last_q  <= (mm_os_q == 4'd8);
              out_valid_q <= 1'b1;
              phase_q     <= PhIdle;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            if (mm_os_q == 4'd8) begin
              mm_os_q <= '0;
              mm_en_q <= 1'b0;
              mm_mr_q <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= StClr;
            end else begin
              mm_os_q <= mm_os_q + 4'd1;
              phase_q <= PhSetup;
            end
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.mm_i      = mm_i_q;
  assign bus.mm_ic     = mm_ic_q;
  assign bus.mm_os     = mm_os_q;
  assign bus.mm_en     = mm_en_q;
  assign bus.mm_mr     = mm_mr_q;

endmodule

// File: tb/tb_matrix_mult_sequencer.sv
// Directed bench for matrix_mult_sequencer with a behavioural serial-load 3x3 multiplier.
module tb_matrix_mult_sequencer;

  logic clk;
  logic mr;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  matrix_mult_sequencer_if bus ();

  matrix_mult_sequencer #(.IC_HIGH(1), .IC_LOW(1), .SETTLE(1)) dut (
    .clk (clk),
    .mr  (mr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: rises 0..17 load A then B, rises 18..26 compute C[0..8].
  logic [3:0] a_m [9];
  logic [3:0] b_m [9];
  logic [9:0] c_m [16];
  int         mdl_cnt;

  always @(posedge bus.mm_ic or posedge bus.mm_mr) begin
    if (bus.mm_mr) begin
      mdl_cnt = 0;
      for (int i = 0; i < 9; i++) begin a_m[i] = '0; b_m[i] = '0; end
      for (int i = 0; i < 16; i++) c_m[i] = '0;
    end else begin
      if (mdl_cnt < 9) a_m[mdl_cnt] = bus.mm_i;
      else if (mdl_cnt < 18) b_m[mdl_cnt - 9] = bus.mm_i;
      else if (mdl_cnt < 27) begin
        int r, c, acc;
        r = (mdl_cnt - 18) / 3;
        c = (mdl_cnt - 18) % 3;
        acc = 0;
        for (int j = 0; j < 3; j++) acc += int'(a_m[r*3+j]) * int'(b_m[j*3+c]);
        c_m[mdl_cnt - 18] = 10'(acc);
      end
      mdl_cnt = mdl_cnt + 1;
    end
  end

  assign bus.mm_matrix = (bus.mm_en && bus.mm_os < 4'd9) ? c_m[bus.mm_os] : 10'd0;

  // Strobe monitor: rise count, high-phase length and mm_i stability.
  logic       prev_ic = 1'b0;
  logic [3:0] prev_mi = '0;
  logic [3:0] mi_rise = '0;
  int         hi_len = 0;
  int         ic_rises = 0;
  int         hi_bad = 0;
  int         mi_bad = 0;

  always @(negedge clk) begin
    if (bus.mm_ic && !prev_ic) begin
      ic_rises = ic_rises + 1;
      hi_len   = 1;
      if (bus.mm_i !== prev_mi) mi_bad = mi_bad + 1;
      mi_rise  = bus.mm_i;
    end else if (bus.mm_ic) begin
      hi_len = hi_len + 1;
      if (bus.mm_i !== mi_rise) mi_bad = mi_bad + 1;
    end else if (prev_ic) begin
      if (hi_len != 1) hi_bad = hi_bad + 1;
      if (bus.mm_i !== mi_rise) mi_bad = mi_bad + 1;
    end
    prev_ic = bus.mm_ic;
    prev_mi = bus.mm_i;
  end

  logic [3:0] elems [18];
  int         acc_cyc [18];
  logic       load_to;
  logic [9:0] res_d [9];
  logic [3:0] res_i [9];
  logic       res_l [9];
  int         n_got;
  int         first_valid_cyc;
  logic       stall_v [5];
  logic [9:0] stall_d [5];
  logic [3:0] stall_i [5];
  int         exp_case1 [9] = '{72, 82, 63, 117, 132, 97, 0, 0, 0};

  task automatic set_case1();
    int v [18] = '{1, 4, 5, 4, 5, 6, 0, 0, 0, 10, 11, 7, 13, 14, 9, 2, 3, 4};
    for (int i = 0; i < 18; i++) elems[i] = 4'(v[i]);
  endtask

  task automatic set_all15();
    for (int i = 0; i < 18; i++) elems[i] = 4'd15;
  endtask

  // Starts and ends on a falling edge; in_valid stays high for the whole load.
  task automatic load_job(input int count);
    load_to     = 1'b0;
    bus.in_valid = 1'b1;
    for (int e = 0; e < count; e++) begin
      int w;
      bus.in_data = elems[e];
      w = 0;
      while (!bus.in_ready && w < 200) begin @(negedge clk); w++; end
      if (!bus.in_ready) load_to = 1'b1;
      acc_cyc[e] = cyc;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(input logic stall_en, input logic [3:0] stall_k);
    int   w;
    logic stalled;
    n_got = 0;
    w = 0;
    stalled = 1'b0;
    first_valid_cyc = -1;
    while (n_got < 9 && w < 400) begin
      @(negedge clk);
      w++;
      if (bus.out_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (stall_en && !stalled && bus.out_idx == stall_k) begin
          stalled = 1'b1;
          bus.out_ready = 1'b0;
          for (int i = 0; i < 5; i++) begin
            stall_v[i] = bus.out_valid;
            stall_d[i] = bus.out_data;
            stall_i[i] = bus.out_idx;
            @(negedge clk);
          end
          bus.out_ready = 1'b1;
        end
        res_d[n_got] = bus.out_data;
        res_i[n_got] = bus.out_idx;
        res_l[n_got] = bus.out_last;
        n_got++;
      end
    end
  endtask

  task automatic test_reset();
    mr = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.mm_mr, bus.in_ready, bus.out_valid, bus.out_last, bus.mm_ic, bus.mm_en, bus.busy}
        !== 7'b1000001) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 1000001", {bus.mm_mr, bus.in_ready, bus.out_valid,
               bus.out_last, bus.mm_ic, bus.mm_en, bus.busy});
    end
    checks++;
    if ({bus.out_data, bus.out_idx, bus.mm_i, bus.mm_os} !== 22'd0) begin
      errors++;
      $display("FAIL reset_data got %h want 0", {bus.out_data, bus.out_idx, bus.mm_i, bus.mm_os});
    end
    mr = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.mm_mr, bus.in_ready} !== 2'b10) begin
      errors++;
      $display("FAIL clr_cycle1 got %b want 10", {bus.mm_mr, bus.in_ready});
    end
    @(negedge clk);
    checks++;
    if ({bus.mm_mr, bus.in_ready, bus.busy} !== 3'b010) begin
      errors++;
      $display("FAIL clr_exit got %b want 010", {bus.mm_mr, bus.in_ready, bus.busy});
    end
  endtask

  task automatic test_case1();
    set_case1();
    load_job(18);
    collect(1'b0, 4'd0);
    checks++;
    if (load_to || n_got != 9) begin
      errors++;
      $display("FAIL case1_timeout got %0d results want 9", n_got);
    end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (res_d[k] !== 10'(exp_case1[k]) || res_i[k] !== 4'(k) || res_l[k] !== (k == 8)) begin
        errors++;
        $display("FAIL case1_res k=%0d got d=%0d i=%0d l=%b want d=%0d i=%0d l=%b", k, res_d[k],
                 res_i[k], res_l[k], exp_case1[k], k, (k == 8));
      end
    end
    checks++;
    if (first_valid_cyc - acc_cyc[17] != 24) begin
      errors++;
      $display("FAIL case1_latency got %0d want 24", first_valid_cyc - acc_cyc[17]);
    end
  endtask

  task automatic test_all15();
    int r0;
    r0 = ic_rises;
    set_all15();
    load_job(18);
    collect(1'b0, 4'd0);
    checks++;
    if (ic_rises - r0 != 27) begin
      errors++;
      $display("FAIL all15_rises got %0d want 27", ic_rises - r0);
    end
    checks++;
    if (load_to || n_got != 9) begin
      errors++;
      $display("FAIL all15_timeout got %0d results want 9", n_got);
    end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (res_d[k] !== 10'd675) begin
        errors++;
        $display("FAIL all15_res k=%0d got %0d want 675", k, res_d[k]);
      end
    end
  endtask

  task automatic test_hold_valid();
    int h0, m0;
    h0 = hi_bad;
    m0 = mi_bad;
    set_case1();
    load_job(18);
    collect(1'b0, 4'd0);
    for (int e = 1; e < 18; e++) begin
      checks++;
      if (acc_cyc[e] - acc_cyc[e-1] != 4) begin
        errors++;
        $display("FAIL hold_interval e=%0d got %0d want 4", e, acc_cyc[e] - acc_cyc[e-1]);
      end
    end
    checks++;
    if (hi_bad - h0 != 0) begin
      errors++;
      $display("FAIL hold_ic_width got %0d bad strobes want 0", hi_bad - h0);
    end
    checks++;
    if (mi_bad - m0 != 0) begin
      errors++;
      $display("FAIL hold_mi_stable got %0d bad samples want 0", mi_bad - m0);
    end
  endtask

  task automatic test_backpressure();
    set_case1();
    load_job(18);
    collect(1'b1, 4'd3);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (stall_v[i] !== 1'b1 || stall_d[i] !== 10'd117 || stall_i[i] !== 4'd3) begin
        errors++;
        $display("FAIL bp_hold t=%0d got v=%b d=%0d i=%0d want v=1 d=117 i=3", i, stall_v[i],
                 stall_d[i], stall_i[i]);
      end
    end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (res_d[k] !== 10'(exp_case1[k]) || res_i[k] !== 4'(k)) begin
        errors++;
        $display("FAIL bp_res k=%0d got d=%0d i=%0d want d=%0d i=%0d", k, res_d[k], res_i[k],
                 exp_case1[k], k);
      end
    end
  endtask

  task automatic test_abort();
    set_all15();
    load_job(7);
    mr = 1'b0;
    #1;
    checks++;
    if ({bus.mm_mr, bus.in_ready, bus.out_valid, bus.mm_ic, bus.mm_en, bus.busy, bus.mm_i}
        !== 10'b1000010000) begin
      errors++;
      $display("FAIL abort_reset got %b want 1000010000", {bus.mm_mr, bus.in_ready,
               bus.out_valid, bus.mm_ic, bus.mm_en, bus.busy, bus.mm_i});
    end
    @(negedge clk);
    mr = 1'b1;
    @(negedge clk);
    test_case1();
  endtask

  task automatic test_back_to_back();
    int w, hi;
    test_case1();
    w = 0;
    while (!bus.mm_mr && w < 20) begin @(negedge clk); w++; end
    hi = 0;
    while (bus.mm_mr && hi < 20) begin @(negedge clk); hi++; end
    checks++;
    if (hi != 2) begin
      errors++;
      $display("FAIL b2b_mr_pulse got %0d want 2", hi);
    end
    test_all15();
  endtask

  initial begin
    mr            = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_case1();
    test_all15();
    test_hold_valid();
    test_backpressure();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
